// File: rtl/modcount_sequencer_if.sv
// Command, config and status bundle for the cascaded modulo-counter time base.
// master drives commands/config (system side); slave is the sequencer.
interface modcount_sequencer_if #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 8
);
    logic                      tick_in;
    logic                      start;
    logic                      stop;
    logic                      clear;
    logic                      cfg_valid;
    logic [1:0]                cfg_stage;
    logic [WIDTH-1:0]          cfg_limit;
    logic                      cfg_ready;
    logic [STAGES*WIDTH-1:0]   count;
    logic [STAGES-1:0]         stage_wrap;
    logic                      carry_out;
    logic [1:0]                state;

    modport master (
        output tick_in, start, stop, clear, cfg_valid, cfg_stage, cfg_limit,
        input  cfg_ready, count, stage_wrap, carry_out, state
    );

    modport slave (
        input  tick_in, start, stop, clear, cfg_valid, cfg_stage, cfg_limit,
        output cfg_ready, count, stage_wrap, carry_out, state
    );
endinterface

// File: rtl/modcount_sequencer.sv
// Cascaded programmable modulo counters (e.g. sec/min/hour) with a
// run/pause/clear FSM, per-stage limit registers and single-cycle carry lookahead.
module modcount_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             term_o,
    output logic             wrap_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   cnt_p1;

    // Limits 0 and 1 are both modulus 1; a count at or above limit-1 is terminal,
    // so lowering the limit under the count forces a wrap on the next advance.
    assign cnt_p1 = {1'b0, cnt_q} + (WIDTH+1)'(1);
    assign term_o = (limit_i <= WIDTH'(1)) || (cnt_p1 >= {1'b0, limit_i});

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d  = term_o ? '0 : cnt_p1[WIDTH-1:0];
            wrap_d = term_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
endmodule

module modcount_sequencer #(
    parameter int STAGES      = 3,
    parameter int WIDTH       = 8,
    parameter int RESET_LIMIT = 10
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    modcount_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;

    state_e                         state_q, state_d;
    logic                           cfg_ready;
    logic                           adv0;
    logic [STAGES-1:0][WIDTH-1:0]   limit_q;
    logic [STAGES-1:0][WIDTH-1:0]   cnt;
    logic [STAGES-1:0]              adv, term, wrap;
    logic                           carry_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // clear > stop > start; start in RUN and stop outside RUN are no-ops.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                RUN:        if (bus.stop)  state_d = PAUSE;
                IDLE,PAUSE: if (bus.start) state_d = RUN;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Ticks only count while staying in RUN; edges that take stop/clear drop them.
    always_comb begin
        cfg_ready = (state_q != RUN);
        adv0      = (state_q == RUN) && bus.tick_in && !bus.clear && !bus.stop;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < STAGES; i++) limit_q[i] <= WIDTH'(RESET_LIMIT);
        end else if (bus.cfg_valid && cfg_ready) begin
            for (int i = 0; i < STAGES; i++)
                if (bus.cfg_stage == 2'(i)) limit_q[i] <= bus.cfg_limit;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign adv[g] = adv0;
        end else begin : g_next
            assign adv[g] = adv[g-1] & term[g-1];
        end

        modcount_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clk_in),
            .rst_n_i (rst_n_in),
            .clr_i   (bus.clear),
            .adv_i   (adv[g]),
            .limit_i (limit_q[g]),
            .cnt_o   (cnt[g]),
            .term_o  (term[g]),
            .wrap_o  (wrap[g])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) carry_q <= 1'b0;
        else           carry_q <= &(adv & term);
    end

    assign bus.cfg_ready  = cfg_ready;
    assign bus.count      = cnt;
    assign bus.stage_wrap = wrap;
    assign bus.carry_out  = carry_q;
    assign bus.state      = state_q;
endmodule

// File: doc/modcount_sequencer.md
Name: modcount_sequencer

Overview:
- Controller and scheduler for a cascade of programmable modulo counter stages, forming a multi-digit time base such as sec/min/hour.
- Owns the per-stage limit registers, a run/pause/clear state machine and cascaded carry sequencing. Stage advances are driven by a base-rate tick enable.
- Sits between the system tick source and consumers of the stage counts and wrap pulses.

Parameters:
STAGES, 3, number of cascaded counter stages (1..4)
WIDTH, 8, bit width of each stage count and limit
RESET_LIMIT, 10, limit loaded into every stage on reset

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
tick_in  input  1  base-rate advance enable, one-cycle pulses
start  input  1  request to enter RUN
stop  input  1  request to enter PAUSE
clear  input  1  synchronous return to IDLE with counts zeroed
cfg_valid  input  1  limit write request
cfg_stage  input  2  target stage index of the write
cfg_limit  input  WIDTH  modulus for the target stage
cfg_ready  output  1  limit write accepted this cycle when cfg_valid is also high
count  output  STAGES*WIDTH  stage counts, stage 0 in the LSBs
stage_wrap  output  STAGES  one-cycle pulse per stage that wrapped to 0
carry_out  output  1  one-cycle pulse when all stages wrap together
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - state=IDLE, count=0, stage_wrap=0, carry_out=0.
  - Every limit register loads RESET_LIMIT.
  - cfg_ready=1 once reset is released.
- All outputs are registered. cfg_ready is decoded from the state register: it is 1 in IDLE and PAUSE, 0 in RUN.
- FSM command priority: clear > stop > start, all evaluated on the same edge.
  - clear, any state: goes to IDLE, count=0. Limits are retained.
  - IDLE or PAUSE with start: goes to RUN.
  - RUN with stop: goes to PAUSE. Counts are held.
  - stop in IDLE or PAUSE: no effect. start in RUN: no effect.
- Config handshake: a write occurs when cfg_valid and cfg_ready are both high at the edge.
  - The write updates limit[cfg_stage].
  - cfg_stage >= STAGES: the write is silently dropped.
  - A write in RUN is ignored entirely. It is not queued.
- Modulus rule: a stage with limit L counts 0..L-1.
  - Terminal condition: count >= L-1, compared at WIDTH+1 bits.
  - L=0 and L=1 both mean modulus 1: count stays 0 and the stage is terminal on every advance.
  - Lowering a limit below the current count makes the stage terminal. Its next advance wraps it to 0 and propagates the carry.
- Advance, only in RUN with tick_in=1 at the edge:
  - Stage 0 advances.
  - Stage i advances only when stages 0..i-1 are all terminal in the same cycle. Evaluation is a single-cycle lookahead, with no ripple delay across cycles.
  - An advancing stage that is terminal goes to 0. An advancing stage that is not terminal goes to count+1.
- Wrap pulses:
  - stage_wrap[i]=1 for exactly the one cycle following an edge on which stage i went from terminal to 0. Otherwise stage_wrap[i]=0.
  - carry_out = AND of stage_wrap, with the same timing.
- Dropped ticks:
  - tick_in outside RUN is dropped.
  - A tick on the edge where stop or clear is taken is dropped.
  - A tick on the edge where start is taken from IDLE/PAUSE is dropped; the first counted tick is on the following edge.
- Consecutive ticks every cycle are fully supported. There is no minimum tick spacing.
- Reset asserted mid-operation: immediate IDLE with zero counts. Limits revert to RESET_LIMIT.

Test Plan:
1. Assert rst_n_in low mid-cycle -> state=0, count=0, stage_wrap=0, carry_out=0 immediately. Release -> cfg_ready=1, all limits 10: nine RUN ticks give count0=9, the tenth gives count0=0 and count1=1.
2. In IDLE write limits 10,6,4 to stages 0,1,2; start; 9 ticks -> count0=9, no wraps. 10th tick -> count0=0, count1=1, stage_wrap=3'b001 for one cycle.
3. Same config, 240 back-to-back ticks -> all counts 0, and stage_wrap=3'b111 plus carry_out=1 for exactly one cycle after the 240th tick. carry_out=0 after ticks 1..239.
4. RUN with count0=5: stop and tick on the same edge -> state=PAUSE, count0 stays 5. cfg write in PAUSE is accepted (cfg_ready=1). cfg write in RUN -> limit unchanged; verify by counting to 10.
5. PAUSE with count0=5: write limit0=3, start, one tick -> count0=0, count1 +1, stage_wrap[0] pulses. Then set limit0=1 -> count0 stays 0 and count1 advances on every tick.
6. RUN with counts 7,2,1 and clear+start+tick asserted on the same edge -> state=IDLE, counts 0, limits unchanged, no wrap pulse. cfg_stage=3 write -> no limit changes.
